dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// DMEM_ARB_FIXED_PRIO_EN: when defined, port A always wins ties.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_write_data,
  output logic              a_gnt,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_read_data,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_write_data,
  output logic              b_gnt,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_read_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              win_b_q, win_b_d;
  logic              pick_b;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
  logic              a_gnt_q, a_gnt_d;
  logic              b_gnt_q, b_gnt_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [DATA_W-1:0] a_read_data_q, a_read_data_d;
  logic [DATA_W-1:0] b_read_data_q, b_read_data_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic              last_b_q, last_b_d;
`endif

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign pick_b = b_req && !a_req;
`else
  assign pick_b = b_req && (!a_req || !last_b_q);
`endif

  always_comb begin
    state_d          = state_q;
    win_b_d          = win_b_q;
    mem_address_d    = mem_address_q;
    mem_we_d         = 1'b0;
    mem_write_data_d = mem_write_data_q;
    a_gnt_d          = 1'b0;
    b_gnt_d          = 1'b0;
    a_ack_d          = 1'b0;
    b_ack_d          = 1'b0;
    a_read_data_d    = a_read_data_q;
    b_read_data_d    = b_read_data_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    last_b_d         = last_b_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          state_d          = ACCESS;
          win_b_d          = pick_b;
          mem_we_d         = pick_b ? b_we : a_we;
          mem_address_d    = pick_b ? b_address : a_address;
          mem_write_data_d = pick_b ? b_write_data : a_write_data;
          a_gnt_d          = !pick_b;
          b_gnt_d          = pick_b;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last_b_d         = pick_b;
`endif
        end
      end
      ACCESS: begin
        // memory has sampled at the preceding negedge; read data is valid now
        state_d = IDLE;
        a_ack_d = !win_b_q;
        b_ack_d = win_b_q;
        if (!mem_we_q && !win_b_q) a_read_data_d = mem_read_data;
        if (!mem_we_q && win_b_q)  b_read_data_d = mem_read_data;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      win_b_q          <= 1'b0;
      mem_address_q    <= '0;
      mem_we_q         <= 1'b0;
      mem_write_data_q <= '0;
      a_gnt_q          <= 1'b0;
      b_gnt_q          <= 1'b0;
      a_ack_q          <= 1'b0;
      b_ack_q          <= 1'b0;
      a_read_data_q    <= '0;
      b_read_data_q    <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_b_q         <= 1'b1;
`endif
    end else begin
      state_q          <= state_d;
      win_b_q          <= win_b_d;
      mem_address_q    <= mem_address_d;
      mem_we_q         <= mem_we_d;
      mem_write_data_q <= mem_write_data_d;
      a_gnt_q          <= a_gnt_d;
      b_gnt_q          <= b_gnt_d;
      a_ack_q          <= a_ack_d;
      b_ack_q          <= b_ack_d;
      a_read_data_q    <= a_read_data_d;
      b_read_data_q    <= b_read_data_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_b_q         <= last_b_d;
`endif
    end
  end

  assign a_gnt          = a_gnt_q;
  assign b_gnt          = b_gnt_q;
  assign a_ack          = a_ack_q;
  assign b_ack          = b_ack_q;
  assign a_read_data    = a_read_data_q;
  assign b_read_data    = b_read_data_q;
  assign mem_address    = mem_address_q;
  assign mem_we         = mem_we_q;
  assign mem_write_data = mem_write_data_q;
  assign busy           = (state_q == ACCESS);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model plus directed scenarios.
// Memory stub samples on negedge; model predicts every cycle.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_address = '0;
  logic [DW-1:0] a_write_data = '0;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_address = '0;
  logic [DW-1:0] b_write_data = '0;
  logic          a_gnt, a_ack, b_gnt, b_ack, mem_we, busy;
  logic [DW-1:0] a_read_data, b_read_data, mem_write_data;
  logic [DW-1:0] mem_read_data = '0;
  logic [AW-1:0] mem_address;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_address(a_address),
    .a_write_data(a_write_data), .a_gnt(a_gnt), .a_ack(a_ack),
    .a_read_data(a_read_data),
    .b_req(b_req), .b_we(b_we), .b_address(b_address),
    .b_write_data(b_write_data), .b_gnt(b_gnt), .b_ack(b_ack),
    .b_read_data(b_read_data),
    .mem_address(mem_address), .mem_we(mem_we),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int tb_cyc = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // memory stub
  logic [DW-1:0] mem [256];
  logic [DW-1:0] shadow [256];
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = DW'(i * 3 + 1);
      shadow[i] = DW'(i * 3 + 1);
    end
  end

  always @(negedge clock) begin
    if (mem_we) mem[mem_address] <= mem_write_data;
    else mem_read_data <= mem[mem_address];
  end

  always @(posedge clock) tb_cyc <= tb_cyc + 1;

  // transaction-level model: one access occupies two cycles
  int            m_cyc = 0;
  int            ack_cyc = -10;
  int            ok_cyc = 0;
  bit            m_last_b = 1'b1;
  bit            pend_b, pend_we;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_wd;
  logic          e_ga, e_gb, e_aa, e_ab, e_we, e_busy;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wd = '0, e_ra = '0, e_rb = '0;
  bit            ar, br, tb_b;

  always @(posedge clock) begin
    ar = a_req;
    br = b_req;
    {e_ga, e_gb, e_aa, e_ab, e_we, e_busy} = '0;
    if (reset) begin
      ack_cyc  = -10;
      ok_cyc   = 0;
      m_last_b = 1'b1;
      e_addr   = '0;
      e_wd     = '0;
      e_ra     = '0;
      e_rb     = '0;
    end else begin
      m_cyc++;
      if (m_cyc == ack_cyc) begin
        if (pend_we) shadow[pend_addr] = pend_wd;
        else if (pend_b) e_rb = shadow[pend_addr];
        else e_ra = shadow[pend_addr];
        e_aa = !pend_b;
        e_ab = pend_b;
      end else if (m_cyc >= ok_cyc && (ar || br)) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        tb_b = !ar;
`else
        tb_b = br && (!ar || !m_last_b);
`endif
        m_last_b  = tb_b;
        pend_b    = tb_b;
        pend_we   = tb_b ? b_we : a_we;
        pend_addr = tb_b ? b_address : a_address;
        pend_wd   = tb_b ? b_write_data : a_write_data;
        e_addr    = pend_addr;
        e_wd      = pend_wd;
        e_we      = pend_we;
        e_ga      = !tb_b;
        e_gb      = tb_b;
        e_busy    = 1'b1;
        ack_cyc   = m_cyc + 1;
        ok_cyc    = m_cyc + 2;
      end
    end
    #1;
    check("a_gnt", a_gnt, e_ga);
    check("b_gnt", b_gnt, e_gb);
    check("a_ack", a_ack, e_aa);
    check("b_ack", b_ack, e_ab);
    check("mem_we", mem_we, e_we);
    check("busy", busy, e_busy);
    check("mem_address", mem_address, e_addr);
    check("mem_write_data", mem_write_data, e_wd);
    check("a_read_data", a_read_data, e_ra);
    check("b_read_data", b_read_data, e_rb);
    check("gnt_both", a_gnt & b_gnt, 1'b0);
    check("ack_both", a_ack & b_ack, 1'b0);
  end

  task automatic wait_gnt(input bit pb, output int at);
    at = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock);
      #2;
      if (pb ? b_gnt : a_gnt) begin
        at = tb_cyc;
        return;
      end
    end
    check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic acc_a(input bit we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd, output int at);
    a_we = we;
    a_address = ad;
    a_write_data = wd;
    a_req = 1'b1;
    wait_gnt(1'b0, at);
    a_req = 1'b0;
  endtask

  task automatic step;
    @(posedge clock);
    #2;
  endtask

  int g0, g1, g2, nb;
  int gs[$];
  int gc[$];

  initial begin
    // reset state
    #3;
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", mem_address, '0);
    check("rst_ra", a_read_data, '0);
    check("rst_gnt", {a_gnt, b_gnt, a_ack, b_ack}, 4'b0);

    // both requesters held from reset release
    a_address = 8'h04;
    b_address = 8'h08;
    a_req = 1'b1;
    b_req = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (a_gnt) begin gs.push_back(0); gc.push_back(tb_cyc); end
      if (b_gnt) begin gs.push_back(1); gc.push_back(tb_cyc); end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("rr_count", gs.size(), 4);
    if (gs.size() == 4) begin
      check("rr_g0", gs[0], 0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      check("rr_g1", gs[1], 0);
      check("rr_g2", gs[2], 0);
      check("rr_g3", gs[3], 0);
`else
      check("rr_g1", gs[1], 1);
      check("rr_g2", gs[2], 0);
      check("rr_g3", gs[3], 1);
`endif
      check("rr_gap", gc[3] - gc[0], 6);
    end
    step();
    step();

    // write then read back on port A
    acc_a(1'b1, 8'h10, 16'h1234, g0);
    check("wr_mem_we", mem_we, 1'b1);
    check("wr_addr", mem_address, 8'h10);
    step();
    check("wr_ack", a_ack, 1'b1);
    check("wr_we_low", mem_we, 1'b0);
    acc_a(1'b0, 8'h10, 16'h0, g0);
    step();
    check("rd_ack", a_ack, 1'b1);
    check("rd_data", a_read_data, 16'h1234);

    // B waits behind A's access
    a_we = 1'b0;
    a_address = 8'h05;
    a_req = 1'b1;
    wait_gnt(1'b0, g0);
    a_req = 1'b0;
    b_we = 1'b0;
    b_address = 8'h20;
    b_req = 1'b1;
    wait_gnt(1'b1, g1);
    b_req = 1'b0;
    check("b_after_a", g1 - g0, 2);
    step();
    check("b_ack", b_ack, 1'b1);
    check("b_rd", b_read_data, 16'h0061);
    check("a_rd_kept", a_read_data, 16'h0010);

    // B pulsed only while busy is discarded
    acc_a(1'b0, 8'h03, 16'h0, g0);
    b_address = 8'h22;
    b_req = 1'b1;
    step();
    b_req = 1'b0;
    nb = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (b_gnt) nb++;
    end
    check("pulse_no_gnt", nb, 0);
    check("pulse_addr", mem_address, 8'h03);

    // back-to-back reads on A
    a_we = 1'b0;
    a_address = 8'h00;
    a_req = 1'b1;
    wait_gnt(1'b0, g0);
    check("b2b_busy", busy, 1'b1);
    a_address = 8'h01;
    wait_gnt(1'b0, g1);
    a_address = 8'h02;
    wait_gnt(1'b0, g2);
    a_req = 1'b0;
    check("b2b_gap1", g1 - g0, 2);
    check("b2b_gap2", g2 - g1, 2);
    step();
    check("b2b_data", a_read_data, 16'h0007);
    step();

    // reset before the memory samples a write
    acc_a(1'b1, 8'h30, 16'hBEEF, g0);
    #1;
    reset = 1'b1;
    #1;
    check("abort_we", mem_we, 1'b0);
    check("abort_gnt", a_gnt, 1'b0);
    check("abort_busy", busy, 1'b0);
    step();
    reset = 1'b0;
    step();
    check("abort_no_ack", a_ack, 1'b0);
    step();
    check("abort_mem", mem[8'h30], 16'h0091);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
